// File: rtl/psx_pad_responder.sv
// PSX digital-pad device: oversamples the host link and answers a 5-byte poll (FF, PAD_ID, 5A, buttons).
// Latency: data valid SYNC_STAGES+2 clk after psx_clk falls; no backpressure, host paces via ack.
module psx_pad_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_DELAY   = 4,
  parameter int         ACK_WIDTH   = 8,
  parameter logic [7:0] PAD_ID      = 8'h41
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] buttons,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  output logic        data,
  output logic        ack,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] clk_sr, cmd_sr, att_sr;
  logic                   clk_prev;
  logic                   psx_clk_s, cmd_s, att_s, clk_fall, clk_rise;

  state_t      state, state_n;
  logic [2:0]  byte_idx, byte_idx_n, bit_idx, bit_idx_n;
  logic [7:0]  tx, tx_n, rx, rx_n, rx_full;
  logic [15:0] btn_q, btn_q_n;
  logic [7:0]  cnt, cnt_n;
  logic        data_n, ack_n, frame_done_n, frame_err_n;

  assign psx_clk_s = clk_sr[SYNC_STAGES-1];
  assign cmd_s     = cmd_sr[SYNC_STAGES-1];
  assign att_s     = att_sr[SYNC_STAGES-1];
  assign clk_fall  = clk_prev & ~psx_clk_s;
  assign clk_rise  = ~clk_prev & psx_clk_s;
  assign busy      = (state == SHIFT) || (state == ACK_WAIT) || (state == ACK_PULSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr     <= '1;
      cmd_sr     <= '1;
      att_sr     <= '1;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      byte_idx   <= '0;
      bit_idx    <= '0;
      tx         <= 8'hFF;
      rx         <= '0;
      btn_q      <= '1;
      cnt        <= '0;
      data       <= 1'b1;
      ack        <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sr     <= {clk_sr[SYNC_STAGES-2:0], psx_clk};
      cmd_sr     <= {cmd_sr[SYNC_STAGES-2:0], cmd};
      att_sr     <= {att_sr[SYNC_STAGES-2:0], att};
      clk_prev   <= psx_clk_s;
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      bit_idx    <= bit_idx_n;
      tx         <= tx_n;
      rx         <= rx_n;
      btn_q      <= btn_q_n;
      cnt        <= cnt_n;
      data       <= data_n;
      ack        <= ack_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    byte_idx_n   = byte_idx;
    bit_idx_n    = bit_idx;
    tx_n         = tx;
    rx_n         = rx;
    btn_q_n      = btn_q;
    cnt_n        = cnt;
    data_n       = data;
    ack_n        = ack;
    frame_done_n = 1'b0;
    frame_err_n  = 1'b0;
    rx_full      = {cmd_s, rx[6:0]};

    // Host dropping att wins over anything else happening this cycle.
    if (att_s) begin
      state_n = IDLE;
      ack_n   = 1'b1;
      data_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n    = SHIFT;
          byte_idx_n = '0;
          bit_idx_n  = '0;
          tx_n       = 8'hFF;
          btn_q_n    = buttons;
          data_n     = 1'b1;
          ack_n      = 1'b1;
        end
        SHIFT: begin
          if (clk_fall) begin
            data_n = tx[bit_idx];
          end else if (clk_rise) begin
            rx_n[bit_idx] = cmd_s;
            bit_idx_n     = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              data_n  = 1'b1;
              cnt_n   = '0;
              state_n = ACK_WAIT;
              case (byte_idx)
                3'd0: if (rx_full != 8'h01) begin
                        frame_err_n = 1'b1;
                        state_n     = IGNORE;
                      end else tx_n = PAD_ID;
                3'd1: if (rx_full != 8'h42) begin
                        frame_err_n = 1'b1;
                        state_n     = IGNORE;
                      end else tx_n = 8'h5A;
                3'd2: tx_n = btn_q[7:0];
                3'd3: tx_n = btn_q[15:8];
                default: begin
                  frame_done_n = 1'b1;
                  state_n      = IGNORE;
                end
              endcase
            end
          end
        end
        ACK_WAIT: begin
          if (cnt == 8'(ACK_DELAY - 1)) begin
            ack_n   = 1'b0;
            cnt_n   = '0;
            state_n = ACK_PULSE;
          end else cnt_n = cnt + 8'd1;
        end
        ACK_PULSE: begin
          if (cnt == 8'(ACK_WIDTH - 1)) begin
            ack_n      = 1'b1;
            byte_idx_n = byte_idx + 3'd1;
            state_n    = SHIFT;
          end else cnt_n = cnt + 8'd1;
        end
        default: begin
          data_n = 1'b1;
          ack_n  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psx_pad_responder.sv
// Directed bench for psx_pad_responder: acts as the PSX host, drives on clk negedge and samples there.
module tb_psx_pad_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] buttons = 16'hFFFE;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic        att = 1'b1;
  logic        data, ack, busy, frame_done, frame_err;

  int n_checks = 0;
  int n_pass = 0;
  int ack_falls = 0;
  int dones = 0;
  int errs = 0;
  logic ack_prev = 1'b1;

  psx_pad_responder dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .psx_clk(psx_clk), .cmd(cmd), .att(att),
    .data(data), .ack(ack), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ack_prev <= ack;
    if (ack_prev && !ack) ack_falls <= ack_falls + 1;
    if (frame_done) dones <= dones + 1;
    if (frame_err) errs <= errs + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One host byte, LSB first, half period 6 clk. lat/w measure ack fall and width after the last rise.
  task automatic xfer_byte(input logic [7:0] c, input bit want_ack, output logic [7:0] r,
                           output int lat, output int w, output bit data_bad);
    lat = 0; w = 0; data_bad = 0; r = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd = c[i];
      wait_clks(6);
      r[i] = data;
      psx_clk = 1'b1;
      if (i < 7) wait_clks(6);
    end
    if (want_ack) begin
      while (ack !== 1'b0 && lat < 40) begin
        @(negedge clk); lat++;
        if (data !== 1'b1) data_bad = 1;
      end
      while (ack !== 1'b1 && w < 40) begin
        @(negedge clk); w++;
        if (data !== 1'b1) data_bad = 1;
      end
    end else begin
      wait_clks(12);
    end
  endtask

  task automatic poll(input logic [15:0] btn_mid, output logic [39:0] r, output int n_ack,
                      output int n_done, output int n_err, output logic busy_mid, output logic busy_end);
    logic [7:0] cmds [5];
    logic [7:0] rb;
    int a0, d0, e0, lat, w;
    bit bad;
    cmds[0] = 8'h01; cmds[1] = 8'h42; cmds[2] = 8'h00; cmds[3] = 8'h00; cmds[4] = 8'h00;
    a0 = ack_falls; d0 = dones; e0 = errs;
    @(negedge clk); att = 1'b0;
    wait_clks(4);
    busy_mid = busy;
    for (int b = 0; b < 5; b++) begin
      if (b == 2) buttons = btn_mid;
      xfer_byte(cmds[b], b < 4, rb, lat, w, bad);
      r[8*b +: 8] = rb;
    end
    busy_end = busy;
    att = 1'b1;
    wait_clks(6);
    n_ack = ack_falls - a0; n_done = dones - d0; n_err = errs - e0;
  endtask

  task automatic test_reset;
    wait_clks(3);
    n_checks++; if (data !== 1'b1) $display("FAIL reset_data got %b want 1", data); else n_pass++;
    n_checks++; if (ack !== 1'b1) $display("FAIL reset_ack got %b want 1", ack); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err); else n_pass++;
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_poll;
    logic [39:0] r; int na, nd, ne; logic bm, be;
    buttons = 16'hFFFE;
    poll(16'hFFFE, r, na, nd, ne, bm, be);
    n_checks++; if (r !== 40'hFF_FE_5A_41_FF) $display("FAIL poll_bytes got %h want ff_fe_5a_41_ff", r); else n_pass++;
    n_checks++; if (na !== 4) $display("FAIL poll_acks got %0d want 4", na); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL poll_done got %0d want 1", nd); else n_pass++;
    n_checks++; if (ne !== 0) $display("FAIL poll_err got %0d want 0", ne); else n_pass++;
    n_checks++; if (bm !== 1'b1) $display("FAIL poll_busy_mid got %b want 1", bm); else n_pass++;
    n_checks++; if (be !== 1'b0) $display("FAIL poll_busy_after_byte4 got %b want 0", be); else n_pass++;
  endtask

  task automatic test_ack_timing;
    logic [7:0] r; int lat, w; bit bad;
    @(negedge clk); att = 1'b0;
    wait_clks(4);
    xfer_byte(8'h01, 1'b1, r, lat, w, bad);
    // 2 sync flops + edge register, then ACK_DELAY
    n_checks++; if (lat !== 7) $display("FAIL ack_latency got %0d want 7", lat); else n_pass++;
    n_checks++; if (w !== 8) $display("FAIL ack_width got %0d want 8", w); else n_pass++;
    n_checks++; if (bad !== 1'b0) $display("FAIL ack_data_high got %b want 0", bad); else n_pass++;
    att = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_bad_header;
    logic [7:0] r; int lat, w, a0, e0; bit bad; logic [39:0] pr; int na, nd, ne; logic bm, be;
    a0 = ack_falls; e0 = errs;
    @(negedge clk); att = 1'b0;
    wait_clks(4);
    xfer_byte(8'h81, 1'b0, r, lat, w, bad);
    xfer_byte(8'h42, 1'b0, r, lat, w, bad);
    n_checks++; if (r !== 8'hFF) $display("FAIL bad_hdr_data got %h want ff", r); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bad_hdr_busy got %b want 0", busy); else n_pass++;
    att = 1'b1;
    wait_clks(6);
    n_checks++; if (errs - e0 !== 1) $display("FAIL bad_hdr_err got %0d want 1", errs - e0); else n_pass++;
    n_checks++; if (ack_falls - a0 !== 0) $display("FAIL bad_hdr_acks got %0d want 0", ack_falls - a0); else n_pass++;
    poll(16'hFFFE, pr, na, nd, ne, bm, be);
    n_checks++; if (pr !== 40'hFF_FE_5A_41_FF) $display("FAIL recover_bytes got %h want ff_fe_5a_41_ff", pr); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL recover_done got %0d want 1", nd); else n_pass++;
  endtask

  task automatic test_abort;
    logic [7:0] r; int lat, w, d0; bit bad;
    d0 = dones;
    @(negedge clk); att = 1'b0;
    wait_clks(4);
    xfer_byte(8'h01, 1'b1, r, lat, w, bad);
    xfer_byte(8'h42, 1'b1, r, lat, w, bad);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); psx_clk = 1'b0; cmd = 1'b0;
      wait_clks(6);
      psx_clk = 1'b1;
      wait_clks(6);
    end
    att = 1'b1;
    wait_clks(2);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_early got %b want 1", busy); else n_pass++;
    wait_clks(1);
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (ack !== 1'b1) $display("FAIL abort_ack got %b want 1", ack); else n_pass++;
    n_checks++; if (data !== 1'b1) $display("FAIL abort_data got %b want 1", data); else n_pass++;
    wait_clks(6);
    n_checks++; if (dones - d0 !== 0) $display("FAIL abort_done got %0d want 0", dones - d0); else n_pass++;
  endtask

  task automatic test_buttons_midframe;
    logic [39:0] r; int na, nd, ne; logic bm, be;
    buttons = 16'hFFFE;
    poll(16'h0000, r, na, nd, ne, bm, be);
    n_checks++; if (r !== 40'hFF_FE_5A_41_FF) $display("FAIL btn_snapshot got %h want ff_fe_5a_41_ff", r); else n_pass++;
    poll(16'h0000, r, na, nd, ne, bm, be);
    n_checks++; if (r !== 40'h00_00_5A_41_FF) $display("FAIL btn_next_frame got %h want 00_00_5a_41_ff", r); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] r; int lat, w; bit bad; logic [39:0] pr; int na, nd, ne; logic bm, be;
    buttons = 16'hFFFE;
    @(negedge clk); att = 1'b0;
    wait_clks(4);
    xfer_byte(8'h01, 1'b0, r, lat, w, bad);
    n_checks++; if (ack !== 1'b0) $display("FAIL rst_mid_in_pulse got %b want 0", ack); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ack !== 1'b1) $display("FAIL rst_mid_ack got %b want 1", ack); else n_pass++;
    n_checks++; if (data !== 1'b1) $display("FAIL rst_mid_data got %b want 1", data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    att = 1'b1;
    wait_clks(6);
    poll(16'hFFFE, pr, na, nd, ne, bm, be);
    n_checks++; if (pr !== 40'hFF_FE_5A_41_FF) $display("FAIL rst_mid_reframe got %h want ff_fe_5a_41_ff", pr); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_poll;
    test_ack_timing;
    test_bad_header;
    test_abort;
    test_buttons_midframe;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
